// File: rtl/lock_pkg.sv
// Shared types and seven-segment glyphs for the parameterised combination lock.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_OPEN    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROG    = 3'd4
  } lock_state_t;

  // Active-low gfedcba patterns for the non-numeric status glyphs.
  localparam logic [6:0] GLYPH_O    = 7'b1000000;
  localparam logic [6:0] GLYPH_F    = 7'b0001110;
  localparam logic [6:0] GLYPH_L    = 7'b1000111;
  localparam logic [6:0] GLYPH_DASH = 7'b0111111;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low seven-segment pattern, segment order gfedcba.
module hex7seg (
  input  logic [3:0] value,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (value)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/param_lock.sv
// Digit-entry combination lock with failure lockout and in-field reprogramming.
// enter is a strobe, not a handshake: every high cycle is one event, no ready/backpressure.
module param_lock
  import lock_pkg::*;
#(
  parameter int                   DIGITS         = 6,
  parameter int                   DW             = 4,
  parameter int                   MAX_FAILS      = 3,
  parameter int                   LOCKOUT_CYCLES = 1000,
  parameter logic [DIGITS*DW-1:0] DEFAULT_CODE   = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] digit_in,
  input  logic          enter,
  input  logic          prog_en,
  output logic [2:0]    state_o,
  output logic [3:0]    digit_idx,
  output logic [3:0]    fail_cnt,
  output logic          unlocked,
  output logic [6:0]    hex0
);

  localparam int         CW       = $clog2(LOCKOUT_CYCLES + 1);
  localparam int         CODE_W   = DIGITS * DW;
  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);
  localparam logic [3:0] MAX_F    = 4'(MAX_FAILS);

  lock_state_t       state_q, state_d;
  logic [3:0]        idx_q, idx_d;
  logic              mis_q, mis_d;
  logic [3:0]        fail_q, fail_d;
  logic [CW-1:0]     lcnt_q, lcnt_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [CODE_W-1:0] shadow_q, shadow_d;

  logic [DW-1:0]     code_digit;
  logic [CODE_W-1:0] shadow_wr;
  logic              mis_now;
  logic [3:0]        fail_inc;
  logic              last_digit;

  assign code_digit = code_q[32'(idx_q) * DW +: DW];
  assign mis_now    = mis_q | (digit_in != code_digit);
  assign fail_inc   = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
  assign last_digit = (idx_q == LAST_IDX);

  always_comb begin
    shadow_wr = shadow_q;
    shadow_wr[32'(idx_q) * DW +: DW] = digit_in;
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    mis_d    = mis_q;
    fail_d   = fail_q;
    lcnt_d   = lcnt_q;
    code_d   = code_q;
    shadow_d = shadow_q;
    case (state_q)
      ST_ENTRY: begin
        if (enter) begin
          if (last_digit) begin
            idx_d = 4'd0;
            mis_d = 1'b0;
            if (!mis_now) begin
              state_d = ST_OPEN;
              fail_d  = 4'd0;
            end else begin
              fail_d = fail_inc;
              if (fail_inc == MAX_F) begin
                state_d = ST_LOCKOUT;
                lcnt_d  = CW'(LOCKOUT_CYCLES - 1);
              end else begin
                state_d = ST_FAIL;
              end
            end
          end else begin
            idx_d = idx_q + 4'd1;
            mis_d = mis_now;
          end
        end
      end
      ST_FAIL: begin
        if (enter) state_d = ST_ENTRY;
      end
      ST_LOCKOUT: begin
        if (lcnt_q == '0) begin
          state_d = ST_ENTRY;
          fail_d  = 4'd0;
        end else begin
          lcnt_d = lcnt_q - CW'(1);
        end
      end
      ST_OPEN: begin
        if (enter) begin
          if (prog_en) begin
            state_d  = ST_PROG;
            idx_d    = 4'd0;
            shadow_d = code_q;
          end else begin
            state_d = ST_ENTRY;
          end
        end
      end
      ST_PROG: begin
        // The live code only changes when the full sequence has been captured.
        if (enter) begin
          shadow_d = shadow_wr;
          if (last_digit) begin
            code_d  = shadow_wr;
            idx_d   = 4'd0;
            state_d = ST_OPEN;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = ST_ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ENTRY;
      idx_q    <= 4'd0;
      mis_q    <= 1'b0;
      fail_q   <= 4'd0;
      lcnt_q   <= '0;
      code_q   <= DEFAULT_CODE;
      shadow_q <= DEFAULT_CODE;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      mis_q    <= mis_d;
      fail_q   <= fail_d;
      lcnt_q   <= lcnt_d;
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

  // Digits wider than a nibble show a dash once they exceed F.
  logic [DW+3:0] din_ext;
  logic [6:0]    hex_seg;
  logic          din_over;

  assign din_ext  = {4'b0000, digit_in};
  assign din_over = |din_ext[DW+3:4];

  hex7seg u_hex7seg (
    .value(din_ext[3:0]),
    .seg  (hex_seg)
  );

  always_comb begin
    hex0 = GLYPH_DASH;
    case (state_q)
      ST_ENTRY, ST_PROG: hex0 = din_over ? GLYPH_DASH : hex_seg;
      ST_OPEN:           hex0 = GLYPH_O;
      ST_FAIL:           hex0 = GLYPH_F;
      ST_LOCKOUT:        hex0 = GLYPH_L;
      default:           hex0 = GLYPH_DASH;
    endcase
  end

  assign state_o   = state_q;
  assign digit_idx = idx_q;
  assign fail_cnt  = fail_q;
  assign unlocked  = (state_q == ST_OPEN) || (state_q == ST_PROG);

endmodule

// File: tb/tb_param_lock.sv
// Bench for param_lock: default build against a queue-based attempt model, plus a 1-digit build.
module tb_param_lock;
  import lock_pkg::*;

  localparam int DIGITS         = 6;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 1000;
  localparam logic [6:0] HEX_TBL [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam int DEF_DIGITS [DIGITS] = '{6, 3, 2, 9, 1, 4};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // default build
  logic [3:0] digit_in = '0;
  logic       enter = 1'b0, prog_en = 1'b0;
  logic [2:0] state_o;
  logic [3:0] digit_idx, fail_cnt;
  logic       unlocked;
  logic [6:0] hex0;

  param_lock #(.DEFAULT_CODE(24'h419236)) dut (
    .clk(clk), .rst(rst), .digit_in(digit_in), .enter(enter), .prog_en(prog_en),
    .state_o(state_o), .digit_idx(digit_idx), .fail_cnt(fail_cnt),
    .unlocked(unlocked), .hex0(hex0));

  // single-digit build
  logic [5:0] digit_in1 = '0;
  logic       enter1 = 1'b0, prog_en1 = 1'b0;
  logic [2:0] state1;
  logic [3:0] digit_idx1, fail_cnt1;
  logic       unlocked1;
  logic [6:0] hex1;

  param_lock #(.DIGITS(1), .DW(6), .LOCKOUT_CYCLES(1), .DEFAULT_CODE(6'd37)) dut1 (
    .clk(clk), .rst(rst), .digit_in(digit_in1), .enter(enter1), .prog_en(prog_en1),
    .state_o(state1), .digit_idx(digit_idx1), .fail_cnt(fail_cnt1),
    .unlocked(unlocked1), .hex0(hex1));

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: whole attempts are collected and compared as sequences
  lock_state_t m_state;
  int m_code [DIGITS];
  int m_buf[$];
  int m_prog[$];
  int m_fail;
  int m_lock_left;
  int m_din;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = ST_ENTRY;
    for (int i = 0; i < DIGITS; i++) m_code[i] = DEF_DIGITS[i];
    m_buf.delete();
    m_prog.delete();
    m_fail = 0;
    m_lock_left = 0;
  endtask

  task automatic model_step(input logic en, input logic pe, input int d);
    bit ok;
    case (m_state)
      ST_ENTRY: if (en) begin
        m_buf.push_back(d);
        if (m_buf.size() == DIGITS) begin
          ok = 1'b1;
          for (int i = 0; i < DIGITS; i++) if (m_buf[i] != m_code[i]) ok = 1'b0;
          m_buf.delete();
          if (ok) begin
            m_state = ST_OPEN;
            m_fail  = 0;
          end else begin
            m_fail = (m_fail < 15) ? m_fail + 1 : 15;
            if (m_fail == MAX_FAILS) begin
              m_state     = ST_LOCKOUT;
              m_lock_left = LOCKOUT_CYCLES;
            end else begin
              m_state = ST_FAIL;
            end
          end
        end
      end
      ST_FAIL: if (en) m_state = ST_ENTRY;
      ST_LOCKOUT: begin
        m_lock_left--;
        if (m_lock_left == 0) begin
          m_state = ST_ENTRY;
          m_fail  = 0;
        end
      end
      ST_OPEN: if (en) begin
        if (pe) begin
          m_state = ST_PROG;
          m_prog.delete();
        end else begin
          m_state = ST_ENTRY;
        end
      end
      ST_PROG: if (en) begin
        m_prog.push_back(d);
        if (m_prog.size() == DIGITS) begin
          for (int i = 0; i < DIGITS; i++) m_code[i] = m_prog[i];
          m_prog.delete();
          m_state = ST_OPEN;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    int exp_idx;
    logic [6:0] exp_hex;
    exp_idx = (m_state == ST_ENTRY) ? m_buf.size() :
              (m_state == ST_PROG)  ? m_prog.size() : 0;
    case (m_state)
      ST_OPEN:    exp_hex = 7'b1000000;
      ST_FAIL:    exp_hex = 7'b0001110;
      ST_LOCKOUT: exp_hex = 7'b1000111;
      default:    exp_hex = HEX_TBL[m_din];
    endcase
    chk({tag, "/state"},    32'(state_o),   32'(m_state));
    chk({tag, "/idx"},      32'(digit_idx), 32'(exp_idx));
    chk({tag, "/fail_cnt"}, 32'(fail_cnt),  32'(m_fail));
    chk({tag, "/unlocked"}, 32'(unlocked),
        32'((m_state == ST_OPEN) || (m_state == ST_PROG)));
    chk({tag, "/hex0"},     32'(hex0),      32'(exp_hex));
  endtask

  // driver: apply inputs for one clock edge, advance model, check after edge
  task automatic step(input string tag, input logic en, input logic pe, input int d);
    enter    = en;
    prog_en  = pe;
    digit_in = 4'(d);
    m_din    = d & 15;
    @(posedge clk);
    model_step(en, pe, d & 15);
    #1;
    check_all(tag);
  endtask

  task automatic enter_seq(input string tag, input int d0, input int d1, input int d2,
                           input int d3, input int d4, input int d5);
    int seq [6];
    seq = '{d0, d1, d2, d3, d4, d5};
    for (int i = 0; i < 6; i++) step(tag, 1'b1, 1'b0, seq[i]);
  endtask

  task automatic wrong_attempt(input string tag);
    step(tag, 1'b1, 1'b0, (6 + $urandom_range(1, 15)) % 16);
    for (int i = 1; i < DIGITS; i++) step(tag, 1'b1, 1'b0, $urandom_range(0, 15));
  endtask

  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all({tag, "_async"});
    @(posedge clk);
    #1;
    check_all({tag, "_held"});
    rst = 1'b0;
  endtask

  task automatic step1(input logic en, input int d);
    enter1    = en;
    prog_en1  = 1'b0;
    digit_in1 = 6'(d);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    model_reset();
    m_din = 0;
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // correct default code
    enter_seq("unlock", 6, 3, 2, 9, 1, 4);
    chk("unlock_open", 32'(state_o), 32'(ST_OPEN));
    chk("unlock_hex", 32'(hex0), 32'(7'b1000000));
    step("relock", 1'b1, 1'b0, 0);

    // wrong second digit, then two more wrong attempts into lockout
    enter_seq("wrong1", 6, 0, 2, 9, 1, 4);
    chk("wrong1_fail", 32'(fail_cnt), 32'd1);
    step("clear1", 1'b1, 1'b0, 7);
    wrong_attempt("wrong2");
    step("clear2", 1'b1, 1'b0, 3);
    wrong_attempt("wrong3");
    chk("lockout_entered", 32'(state_o), 32'(ST_LOCKOUT));
    for (int c = 1; c < LOCKOUT_CYCLES; c++)
      step("lockout", 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 15));
    chk("lockout_last", 32'(state_o), 32'(ST_LOCKOUT));
    step("lockout_exit", 1'b0, 1'b0, 0);
    chk("lockout_exit_state", 32'(state_o), 32'(ST_ENTRY));
    chk("lockout_exit_fail", 32'(fail_cnt), 32'd0);

    // reprogram the code
    enter_seq("prog_unlock", 6, 3, 2, 9, 1, 4);
    step("prog_req", 1'b1, 1'b1, 5);
    enter_seq("prog_digits", 1, 1, 2, 2, 3, 3);
    chk("prog_done", 32'(state_o), 32'(ST_OPEN));
    step("prog_relock", 1'b1, 1'b0, 0);
    enter_seq("old_code", 6, 3, 2, 9, 1, 4);
    chk("old_code_rejected", 32'(state_o), 32'(ST_FAIL));
    step("clear3", 1'b1, 1'b0, 0);
    enter_seq("new_code", 1, 1, 2, 2, 3, 3);
    chk("new_code_open", 32'(state_o), 32'(ST_OPEN));

    // async reset partway through programming
    step("prog_req2", 1'b1, 1'b1, 0);
    for (int i = 0; i < 3; i++) step("prog_part", 1'b1, 1'b0, 8 + i);
    enter = 1'b0;
    do_reset("mid_prog_rst");
    chk("mid_prog_entry", 32'(state_o), 32'(ST_ENTRY));
    enter_seq("default_after_rst", 6, 3, 2, 9, 1, 4);
    chk("default_after_rst_open", 32'(state_o), 32'(ST_OPEN));

    // random soak, biased towards correct digits
    for (int c = 0; c < 400; c++) begin
      d = $urandom_range(0, 15);
      if (m_state == ST_ENTRY && $urandom_range(0, 3) != 0) d = m_code[m_buf.size()];
      step("soak", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0), d);
    end

    // single-digit build
    enter = 1'b0;
    do_reset("rst_small");
    chk("s_reset_state", 32'(state1), 32'(ST_ENTRY));
    step1(1'b1, 37);
    chk("s_open", 32'(state1), 32'(ST_OPEN));
    chk("s_unlocked", 32'(unlocked1), 32'd1);
    step1(1'b1, 0);
    chk("s_relock", 32'(state1), 32'(ST_ENTRY));
    step1(1'b0, 40);
    chk("s_hex_dash", 32'(hex1), 32'(7'b0111111));
    step1(1'b0, 10);
    chk("s_hex_a", 32'(hex1), 32'(7'b0001000));
    step1(1'b1, 40);
    chk("s_fail1", 32'(state1), 32'(ST_FAIL));
    chk("s_fail1_cnt", 32'(fail_cnt1), 32'd1);
    step1(1'b1, 0);
    step1(1'b1, 40);
    step1(1'b1, 0);
    step1(1'b1, 40);
    chk("s_lockout", 32'(state1), 32'(ST_LOCKOUT));
    chk("s_lockout_cnt", 32'(fail_cnt1), 32'd3);
    step1(1'b1, 37);
    chk("s_lockout_exit", 32'(state1), 32'(ST_ENTRY));
    chk("s_lockout_exit_cnt", 32'(fail_cnt1), 32'd0);
    step1(1'b1, 37);
    chk("s_reopen", 32'(state1), 32'(ST_OPEN));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_lock.md
PARAM_LOCK -- requirements
Module: param_lock

Interface
REQ-001 Parameter DIGITS, default 6, is the combination length in digits, legal range 1..16.
REQ-002 Parameter DW, default 4, is the width of each digit in bits.
REQ-003 Parameter MAX_FAILS, default 3, is the number of consecutive failed attempts that triggers lockout, legal range 1..15.
REQ-004 Parameter LOCKOUT_CYCLES, default 1000, is the lockout duration in clk cycles, minimum 1.
REQ-005 Parameter DEFAULT_CODE, width DIGITS*DW, is the reset combination; digit 0 occupies bits [DW-1:0] and is entered first.
REQ-006 clk  input  1  is the single clock; all state updates on posedge clk.
REQ-007 rst  input  1  is the asynchronous, active-high reset.
REQ-008 digit_in  input  DW  is the digit value sampled when enter=1.
REQ-009 enter  input  1  is a one-cycle strobe; every cycle it is high counts as one event.
REQ-010 prog_en  input  1  requests reprogramming; it is sampled only in OPEN together with enter.
REQ-011 state_o  output  3  is the current state encoding (lock_state_t).
REQ-012 digit_idx  output  4  is the index of the next digit expected in ENTRY or PROG.
REQ-013 fail_cnt  output  4  is the count of consecutive failed attempts.
REQ-014 unlocked  output  1  is high only in OPEN and PROG.
REQ-015 hex0  output  7  is the active-low seven-segment pattern (gfedcba), decoded as defined in REQ-029.

Function
REQ-016 The block SHALL implement states ENTRY, OPEN, FAIL, LOCKOUT and PROG, encoded as lock_state_t.
REQ-017 ENTRY: each enter SHALL consume digit_in at digit_idx, increment digit_idx, and OR into a registered mismatch flag when digit_in differs from code[digit_idx].
REQ-018 A wrong digit SHALL NOT abort entry; every attempt consumes exactly DIGITS strobes.
REQ-019 On the DIGITS-th enter strobe, with the current digit's mismatch included combinationally:
- state SHALL go to OPEN if there is no mismatch, otherwise to FAIL;
- digit_idx and the mismatch flag SHALL clear;
- the new state SHALL be visible the cycle after the strobe.
REQ-020 Reaching OPEN SHALL clear fail_cnt to 0.
REQ-021 Entering FAIL SHALL increment fail_cnt, saturating at 15.
REQ-022 Lockout entry: if the incremented fail_cnt equals MAX_FAILS, state SHALL go to LOCKOUT instead of FAIL, and the lockout counter SHALL load LOCKOUT_CYCLES-1.
REQ-023 FAIL: the next enter strobe SHALL return to ENTRY; digit_in is ignored on that strobe.
REQ-024 LOCKOUT:
- the counter SHALL decrement every cycle;
- all enter strobes SHALL be ignored;
- when the counter is 0, state SHALL go to ENTRY and fail_cnt SHALL clear.
REQ-025 OPEN: enter with prog_en=1 SHALL go to PROG with digit_idx=0; enter with prog_en=0 SHALL relock to ENTRY.
REQ-026 PROG:
- each enter SHALL write digit_in into a shadow register at digit_idx;
- after the DIGITS-th strobe, the shadow register SHALL copy to the live code register in one cycle, and state SHALL return to OPEN.
REQ-027 A partial PROG sequence SHALL NOT alter the live code.
REQ-028 The comparison SHALL always use the live code, and the shadow register SHALL reload from the live code on entry to PROG.
REQ-029 hex0 decoding by state:
- ENTRY and PROG: digit_in decoded; values 0..F use the standard hex glyphs, and values above F (DW>4) show dash 0111111.
- OPEN: 'O' (1000000).
- FAIL: 'F' (0001110).
- LOCKOUT: 'L' (1000111).

Reset
REQ-030 While rst=1, the block SHALL hold the following values, independent of clk:
- state=ENTRY, digit_idx=0, mismatch=0, fail_cnt=0, lockout counter=0;
- live code and shadow code equal to DEFAULT_CODE;
- unlocked=0.
REQ-031 Reset asserted mid-entry, mid-PROG or mid-lockout SHALL discard all progress and any programmed code.
REQ-032 Outputs SHALL be valid combinationally from registered state during reset.

Structure
REQ-033 Package lock_pkg SHALL hold lock_state_t and the glyph constants GLYPH_O, GLYPH_F, GLYPH_L and GLYPH_DASH.
REQ-034 The seven-segment decode SHALL be a sub-module hex7seg (input 4-bit value, output 7-bit active-low pattern), instantiated once.
REQ-035 The lockout counter width SHALL be $clog2(LOCKOUT_CYCLES+1).

Verification
REQ-036 Use defaults with DEFAULT_CODE digits 6,3,2,9,1,4 in entry order. Enter 6,3,2,9,1,4 -> OPEN one cycle after the 6th strobe, unlocked=1, hex0=1000000.
REQ-037 Enter 6,0,2,9,1,4 -> FAIL only after the 6th strobe, with no earlier state change, fail_cnt=1, hex0=0001110.
REQ-038 Three wrong attempts, each followed by a clear strobe between attempts -> LOCKOUT after the 3rd. Strobes during lockout are ignored. ENTRY is reached exactly 1000 cycles after LOCKOUT entry, with fail_cnt=0.
REQ-039 Program a new code:
- from OPEN: prog_en=1 with enter, then enter 1,1,2,2,3,3 -> OPEN;
- relock with enter (prog_en=0);
- the old code is rejected -> FAIL;
- after a clear strobe, 1,1,2,2,3,3 -> OPEN.
REQ-040 Assert rst asynchronously in PROG after 3 digits -> immediate ENTRY, and DEFAULT_CODE unlocks afterwards.
REQ-041 Build with DIGITS=1, DW=6 and LOCKOUT_CYCLES=1: a one-strobe unlock works, digit_in=40 gives hex0=0111111, and lockout lasts exactly 1 cycle.
